// File: rtl/adder_seq_ctrl_pkg.sv
// Shared types and constants for the serial 2-bit-slice adder controller.
package adder_seq_ctrl_pkg;

   localparam int SLICE_W = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Slice index width, never narrower than one bit (WIDTH=2 has a single slice).
   function automatic int idx_width(input int width);
      return (width / SLICE_W > 1) ? $clog2(width / SLICE_W) : 1;
   endfunction

endpackage

// File: rtl/adder_seq_ctrl_if.sv
// Request/result bundle between a requester (master) and the serial adder (slave).
interface adder_seq_ctrl_if #(parameter int WIDTH = 8);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/adder_seq_ctrl_adder.sv
// 2-bit full-adder slice: {cout, sum} = a + b + cin.
module adder (
   input  logic [1:0] a,
   input  logic [1:0] b,
   input  logic       cin,
   output logic [1:0] sum,
   output logic       cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// File: rtl/adder_seq_ctrl.sv
// Serial adder: computes a+b+cin two bits per cycle through a single 2-bit slice.
//
//   state | meaning
//   IDLE  | waiting for start; operands latched on the accepting edge
//   RUN   | one slice processed per edge, busy=1
//   DONE  | one-cycle done pulse, sum/cout valid; returns to IDLE
module adder_seq_ctrl
   import adder_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic clk,
   input  logic rst_n,
   adder_seq_ctrl_if.slave bus
);

   localparam int STEPS = WIDTH / SLICE_W;
   localparam int IDX_W = idx_width(WIDTH);
   localparam logic [IDX_W-1:0] LAST = IDX_W'(STEPS - 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic               carry;
   logic [WIDTH-1:0]   sh_a;
   logic [WIDTH-1:0]   sh_b;
   logic [WIDTH-1:0]   part;
   logic [WIDTH-1:0]   part_next;
   logic [SLICE_W-1:0] slice_sum;
   logic               slice_cout;

   adder u_slice (
      .a    (sh_a[SLICE_W-1:0]),
      .b    (sh_b[SLICE_W-1:0]),
      .cin  (carry),
      .sum  (slice_sum),
      .cout (slice_cout)
   );

   // Partial result with the current slice merged in, so the final edge can
   // load sum directly without waiting an extra cycle.
   always_comb begin
      part_next = part;
      part_next[SLICE_W*int'(idx) +: SLICE_W] = slice_sum;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         idx      <= '0;
         carry    <= 1'b0;
         sh_a     <= '0;
         sh_b     <= '0;
         part     <= '0;
         bus.busy <= 1'b0;
         bus.done <= 1'b0;
         bus.sum  <= '0;
         bus.cout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               bus.done <= 1'b0;
               if (bus.start) begin
                  sh_a     <= bus.a;
                  sh_b     <= bus.b;
                  carry    <= bus.cin;
                  idx      <= '0;
                  state    <= RUN;
                  bus.busy <= 1'b1;
               end
            end
            RUN: begin
               part  <= part_next;
               carry <= slice_cout;
               sh_a  <= sh_a >> SLICE_W;
               sh_b  <= sh_b >> SLICE_W;
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  bus.sum  <= part_next;
                  bus.cout <= slice_cout;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
                  state    <= DONE;
               end
            end
            DONE: begin
               bus.done <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               bus.done <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Directed bench for adder_seq_ctrl at WIDTH=8 and WIDTH=2.
module tb_adder_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   logic [7:0] prev_sum;
   logic       prev_cout;

   always #5 clk = ~clk;

   adder_seq_ctrl_if #(.WIDTH(8)) if8 ();
   adder_seq_ctrl_if #(.WIDTH(2)) if2 ();

   adder_seq_ctrl #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if8.slave)
   );

   adder_seq_ctrl #(.WIDTH(2)) dut2 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (if2.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issue one WIDTH=8 op, scramble the inputs after acceptance, and check
   // busy/done timing, held outputs during RUN, the result and single pulse.
   task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                         input logic ci, input logic [7:0] es, input logic ec);
      int  n;
      bit  got;
      if8.start = 1'b1;
      if8.a     = av;
      if8.b     = bv;
      if8.cin   = ci;
      tick();
      if8.start = 1'b0;
      if8.a     = ~av;
      if8.b     = ~bv;
      if8.cin   = ~ci;
      chk({tag, "_busy_acc"}, 32'(if8.busy), 32'd1);
      chk({tag, "_sum_held"}, 32'(if8.sum), 32'(prev_sum));
      n   = 0;
      got = 1'b0;
      while (!got && n < 10) begin
         tick();
         n++;
         if (if8.done) got = 1'b1;
         else chk({tag, "_busy_run"}, 32'(if8.busy), 32'd1);
      end
      chk({tag, "_latency"}, 32'(n), 32'd4);
      chk({tag, "_sum"}, 32'(if8.sum), 32'(es));
      chk({tag, "_cout"}, 32'(if8.cout), 32'(ec));
      chk({tag, "_busy_done"}, 32'(if8.busy), 32'd0);
      tick();
      chk({tag, "_done_pulse"}, 32'(if8.done), 32'd0);
      chk({tag, "_sum_keep"}, 32'(if8.sum), 32'(es));
      prev_sum  = es;
      prev_cout = ec;
   endtask

   initial begin
      rst_n     = 1'b0;
      if8.start = 1'b0;
      if8.a     = 8'h00;
      if8.b     = 8'h00;
      if8.cin   = 1'b0;
      if2.start = 1'b0;
      if2.a     = 2'b00;
      if2.b     = 2'b00;
      if2.cin   = 1'b0;
      prev_sum  = 8'h00;
      prev_cout = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(if8.busy), 32'd0);
      chk("rst_done", 32'(if8.done), 32'd0);
      chk("rst_sum",  32'(if8.sum),  32'd0);
      chk("rst_cout", 32'(if8.cout), 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_no_start", 32'(if8.busy), 32'd0);

      run_op("5a_a5", 8'h5A, 8'hA5, 1'b0, 8'hFF, 1'b0);
      run_op("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
      run_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
      run_op("3c_c3_c", 8'h3C, 8'hC3, 1'b1, 8'h00, 1'b1);

      // start re-pulsed during the 2nd RUN cycle must be ignored.
      if8.start = 1'b1;
      if8.a     = 8'h12;
      if8.b     = 8'h34;
      if8.cin   = 1'b0;
      tick();
      if8.start = 1'b0;
      tick();
      if8.start = 1'b1;
      if8.a     = 8'h00;
      if8.b     = 8'h00;
      tick();
      if8.start = 1'b0;
      chk("ign_busy", 32'(if8.busy), 32'd1);
      tick();
      chk("ign_pre_done", 32'(if8.done), 32'd0);
      tick();
      chk("ign_done", 32'(if8.done), 32'd1);
      chk("ign_sum", 32'(if8.sum), 32'h46);
      chk("ign_cout", 32'(if8.cout), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("ign_no_extra", 32'({if8.done, if8.busy}), 32'd0);
      end
      prev_sum = 8'h46;

      // Reset in the 3rd RUN cycle aborts; start during reset is ignored.
      if8.start = 1'b1;
      if8.a     = 8'h5A;
      if8.b     = 8'hA5;
      if8.cin   = 1'b0;
      tick();
      if8.start = 1'b0;
      tick();
      tick();
      rst_n     = 1'b0;
      if8.start = 1'b1;
      tick();
      rst_n     = 1'b1;
      if8.start = 1'b0;
      chk("abort_busy", 32'(if8.busy), 32'd0);
      chk("abort_done", 32'(if8.done), 32'd0);
      chk("abort_sum",  32'(if8.sum),  32'd0);
      chk("abort_cout", 32'(if8.cout), 32'd0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("abort_quiet", 32'({if8.done, if8.busy}), 32'd0);
      end
      prev_sum  = 8'h00;
      prev_cout = 1'b0;
      run_op("03_01", 8'h03, 8'h01, 1'b0, 8'h04, 1'b0);

      // WIDTH=2: 3+1+1 = 5 -> sum 01, cout 1, done one edge after accept.
      if2.start = 1'b1;
      if2.a     = 2'b11;
      if2.b     = 2'b01;
      if2.cin   = 1'b1;
      tick();
      if2.start = 1'b0;
      if2.a     = 2'b00;
      if2.b     = 2'b00;
      if2.cin   = 1'b0;
      chk("w2_busy", 32'({if2.done, if2.busy}), 32'd1);
      tick();
      chk("w2_done", 32'(if2.done), 32'd1);
      chk("w2_busy_off", 32'(if2.busy), 32'd0);
      chk("w2_sum", 32'(if2.sum), 32'd1);
      chk("w2_cout", 32'(if2.cout), 32'd1);
      tick();
      chk("w2_pulse", 32'(if2.done), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adder_seq_ctrl.md
ADDER_SEQ_CTRL -- requirements
Module: adder_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; even, >= 2.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request a WIDTH-bit add; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; sampled on the accepting edge only.
REQ-006 Port: b  input  WIDTH  operand B; sampled on the accepting edge only.
REQ-007 Port: cin  input  1  carry-in; sampled on the accepting edge only.
REQ-008 Port: busy  output  1  high while slices are being processed (RUN).
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: sum  output  WIDTH  registered result.
REQ-011 Port: cout  output  1  registered final carry-out.

Function
REQ-012 The block SHALL compute a+b+cin serially, 2 bits per cycle, through one instance of the team's 2-bit adder slice (ports a, b, cin, sum, cout).
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch a and b into shift registers, latch cin into the carry register, clear the slice index, and enter RUN.
REQ-015 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-016 Each RUN edge SHALL do the following:
- feed the low 2 bits of each shift register plus the carry register to the slice;
- write the slice sum into partial-result bits [2i+1:2i];
- load the slice cout into the carry register;
- shift both operand registers right by 2;
- increment the index.
REQ-017 On the RUN edge that processes index WIDTH/2-1, the block SHALL do the following:
- load sum from the completed partial result;
- load cout from that slice's cout;
- enter DONE.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 done SHALL go high exactly WIDTH/2 clock edges after the accepting edge (4 for WIDTH=8; 1 for WIDTH=2).
REQ-020 busy SHALL be 1 in RUN only; busy and done SHALL never both be 1.
REQ-021 start asserted in RUN or DONE SHALL be ignored without side effects; the requester must hold or reassert start in IDLE.
REQ-022 sum and cout SHALL hold the previous result during RUN and IDLE, changing only on entry to DONE.
REQ-023 Changes on a, b or cin after the accepting edge SHALL NOT affect the result.
REQ-024 Arithmetic SHALL be modulo 2^WIDTH in sum, with the carry out of bit WIDTH-1 reported in cout.

Reset
REQ-025 With rst_n=0 at an edge, the block SHALL enter IDLE and set busy=0, done=0, sum=0, cout=0, and clear the index, carry and shift registers.
REQ-026 Reset during RUN or DONE SHALL abort the operation with no done pulse; the next accepted start SHALL behave as after power-up.
REQ-027 start SHALL be ignored in any cycle where rst_n=0.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, RUN, DONE) and the constant SLICE_W=2.
REQ-029 The 2-bit adder SHALL be the only sub-module, named adder, instantiated once; all other logic lives in adder_seq_ctrl.
REQ-030 The index width SHALL be $clog2(WIDTH/2), with a minimum of 1 bit.

Verification
REQ-031 Bench SHALL cover these scenarios (WIDTH=8 unless stated):
- a=8'h5A, b=8'hA5, cin=0, start 1 cycle -> busy for 4 cycles, then done pulse with sum=8'hFF, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> carry ripples through all slices; sum=8'h00, cout=1.
- a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- start pulsed in the 2nd RUN cycle with a=8'h00 -> ignored; original result delivered, no extra done.
- rst_n=0 for 1 cycle during the 3rd RUN cycle -> no done; outputs 0; a following op 8'h03+8'h01 gives sum=8'h04, cout=0.
- WIDTH=2: a=2'b11, b=2'b01, cin=1 -> done 1 edge after accept; sum=2'b01, cout=1.
